des_key_sequencer: RTL and testbench

- Control-side counterpart of the DES subkey generator: produces the round/pass control the generator consumes, namely `round_count`, `key_count`, `cnt_rollover`, `key_rollover`, `key_enable` and `reverse`.
- Runs one triple-DES operation per `start`: 3 passes × (1 load cycle + 16 round cycles).
- Tells the Feistel datapath when a valid subkey is on the generator output.
- Sits between the top-level encrypt/decrypt FSM and the key generator plus round datapath.

---
 rtl/des_key_sequencer.sv | 96 +++++++++
 tb/tb_des_key_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/des_key_sequencer.sv
// des_key_sequencer: round/pass control for the DES subkey generator across one triple-DES operation.
// Each operation runs PASSES passes, and each pass is one load cycle followed by ROUNDS round cycles.
module des_key_sequencer #(
    parameter int ROUNDS = 16,
    parameter int PASSES = 3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       reverse_in,
    input  logic       hold,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       reverse,
    output logic       key_enable,
    output logic [4:0] round_count,
    output logic [1:0] key_count,
    output logic       cnt_rollover,
    output logic       key_rollover,
    output logic       subkey_valid
);
    typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINISH} state_t;
    localparam logic [4:0] LAST_R = 5'(ROUNDS);
    localparam logic [1:0] LAST_K = 2'(PASSES - 1);
    state_t     state_q, state_d;
    logic [4:0] rnd_q, rnd_d;
    logic [1:0] key_q, key_d;
    logic       rev_q, rev_d;
    logic       valid_q, valid_d;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            rnd_q   <= 5'd0;
            key_q   <= 2'd0;
            rev_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            key_q   <= key_d;
            rev_q   <= rev_d;
            valid_q <= valid_d;
        end
    end
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        key_d   = key_q;
        rev_d   = rev_q;
        valid_d = 1'b0;
        if (abort) begin
            state_d = IDLE;
            rnd_d   = 5'd0;
            key_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = LOAD;
                    rev_d   = reverse_in;
                    rnd_d   = 5'd0;
                    key_d   = 2'd0;
                end
                LOAD: if (!hold) begin
                    state_d = ROUND;
                    rnd_d   = 5'd1;
                end
                ROUND: if (!hold) begin
                    // generator output lags the round counter by one register stage
                    valid_d = 1'b1;
                    if (rnd_q != LAST_R) rnd_d = rnd_q + 5'd1;
                    else if (key_q == LAST_K) state_d = FINISH;
                    else begin
                        state_d = LOAD;
                        rnd_d   = 5'd0;
                        key_d   = key_q + 2'd1;
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                    rnd_d   = 5'd0;
                    key_d   = 2'd0;
                end
            endcase
        end
    end
    assign busy         = (state_q == LOAD) || (state_q == ROUND);
    assign done         = state_q == FINISH;
    assign key_enable   = busy && !hold;
    assign cnt_rollover = (state_q == ROUND) && (rnd_q == LAST_R) && !hold;
    assign key_rollover = cnt_rollover && (key_q == LAST_K);
    assign reverse      = rev_q;
    assign round_count  = rnd_q;
    assign key_count    = key_q;
    assign subkey_valid = valid_q;
endmodule

// File: tb/tb_des_key_sequencer.sv
// tb_des_key_sequencer: step-indexed reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_des_key_sequencer;
    localparam int ROUNDS = 16;
    localparam int PASSES = 3;
    localparam int P1 = ROUNDS + 1;
    localparam int STEPS = PASSES * P1;
    logic clk = 1'b0, n_rst = 1'b0, start = 1'b0, reverse_in = 1'b0, hold = 1'b0, abort = 1'b0;
    logic busy, done, reverse, key_enable, cnt_rollover, key_rollover, subkey_valid;
    logic [4:0] round_count;
    logic [1:0] key_count;
    des_key_sequencer #(.ROUNDS(ROUNDS), .PASSES(PASSES)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .reverse_in(reverse_in), .hold(hold), .abort(abort),
        .busy(busy), .done(done), .reverse(reverse), .key_enable(key_enable), .round_count(round_count),
        .key_count(key_count), .cnt_rollover(cnt_rollover), .key_rollover(key_rollover),
        .subkey_valid(subkey_valid)
    );
    always #5 clk = ~clk;
    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    // model: mode 0 idle, 1 active, 2 finish; m_s counts un-held active cycles of the operation
    int m_mode = 0, m_s = 0;
    logic m_rev = 1'b0, m_valid = 1'b0;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_mode <= 0; m_s <= 0; m_rev <= 1'b0; m_valid <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            if (abort) begin
                m_mode <= 0; m_s <= 0;
            end else if (m_mode == 0) begin
                if (start) begin m_mode <= 1; m_s <= 0; m_rev <= reverse_in; end
            end else if (m_mode == 1) begin
                if (!hold) begin
                    m_valid <= (m_s % P1) != 0;
                    if (m_s == STEPS - 1) m_mode <= 2;
                    else m_s <= m_s + 1;
                end
            end else m_mode <= 0;
        end
    end
    int cyc = 0, t0 = 0, rel;
    always @(posedge clk) cyc <= cyc + 1;
    int n_valid, n_ke, n_cro, n_kro, n_done, done_cyc, kro_cyc;
    int cro[8];
    logic [4:0] snap_rc[64];
    logic [1:0] snap_kc[64];
    logic snap_ke[64], snap_busy[64], snap_rev[64];
    always @(negedge clk) begin
        if (n_rst) begin
            chk("busy", busy, m_mode == 1);
            chk("done", done, m_mode == 2);
            chk("reverse", reverse, m_rev);
            chk("key_enable", key_enable, m_mode == 1 && !hold);
            chk("subkey_valid", subkey_valid, m_valid);
            chk("cnt_rollover", cnt_rollover, m_mode == 1 && !hold && m_s % P1 == ROUNDS);
            chk("key_rollover", key_rollover, m_mode == 1 && !hold && m_s == STEPS - 1);
            if (m_mode != 2) begin
                chk("round_count", round_count, m_mode == 1 ? m_s % P1 : 0);
                chk("key_count", key_count, m_mode == 1 ? m_s / P1 : 0);
            end
            rel = cyc - t0;
            if (subkey_valid) n_valid++;
            if (key_enable) n_ke++;
            if (cnt_rollover && n_cro < 8) begin cro[n_cro] = rel; n_cro++; end
            if (key_rollover) begin kro_cyc = rel; n_kro++; end
            if (done) begin done_cyc = rel; n_done++; end
            if (rel >= 0 && rel < 64) begin
                snap_rc[rel] = round_count; snap_kc[rel] = key_count; snap_ke[rel] = key_enable;
                snap_busy[rel] = busy; snap_rev[rel] = reverse;
            end
        end
    end
    task automatic op(input logic rev, input int hs, input int hl, input int ab, input int ig1, input int ig2,
                      input int ncyc);
        @(posedge clk); #1;
        n_valid = 0; n_ke = 0; n_cro = 0; n_kro = 0; n_done = 0; done_cyc = -1; kro_cyc = -1;
        t0 = cyc; start = 1'b1; reverse_in = rev;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            start = (c == ig1) || (c == ig2);
            reverse_in = start ? ~rev : rev;
            hold = c >= hs && c < hs + hl;
            abort = c == ab;
        end
        start = 1'b0; hold = 1'b0; abort = 1'b0;
        @(negedge clk); #1;
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0); chk("rst_rc", round_count, 0); chk("rst_kc", key_count, 0);
        chk("rst_rev", reverse, 0); chk("rst_valid", subkey_valid, 0);
        n_rst = 1'b1;
        // encrypt with ignored starts mid-run and in FINISH
        op(1'b0, -10, 0, -1, 10, 52, 54);
        chk("enc_done_cyc", done_cyc, 52); chk("enc_n_done", n_done, 1);
        chk("enc_n_valid", n_valid, 48); chk("enc_n_ke", n_ke, 51);
        chk("enc_n_cro", n_cro, 3); chk("enc_cro0", cro[0], 17); chk("enc_cro1", cro[1], 34);
        chk("enc_cro2", cro[2], 51); chk("enc_kro", kro_cyc, 51); chk("enc_n_kro", n_kro, 1);
        chk("enc_rev", reverse, 0); chk("enc_idle", busy, 0);
        // decrypt, then a plain encrypt must clear reverse at acceptance
        op(1'b1, -10, 0, -1, -1, -1, 54);
        chk("dec_done_cyc", done_cyc, 52); chk("dec_rev1", snap_rev[1], 1); chk("dec_rev_after", reverse, 1);
        op(1'b0, -10, 0, -1, -1, -1, 2);
        chk("enc2_rev1", snap_rev[1], 0);
        repeat (60) @(posedge clk);
        // hold 3 cycles at round 5 of pass 1
        op(1'b0, 23, 3, -1, -1, -1, 57);
        chk("hold_done_cyc", done_cyc, 55); chk("hold_n_ke", n_ke, 51); chk("hold_n_valid", n_valid, 48);
        chk("hold_rc24", snap_rc[24], 5); chk("hold_kc24", snap_kc[24], 1); chk("hold_ke24", snap_ke[24], 0);
        chk("hold_rc26", snap_rc[26], 5); chk("hold_ke26", snap_ke[26], 1); chk("hold_rc27", snap_rc[27], 6);
        // hold on the pass-0 rollover
        op(1'b0, 17, 2, -1, -1, -1, 56);
        chk("hro_n_cro", n_cro, 3); chk("hro_cro0", cro[0], 19); chk("hro_cro1", cro[1], 36);
        chk("hro_rc17", snap_rc[17], 16); chk("hro_kc20", snap_kc[20], 1); chk("hro_rc20", snap_rc[20], 0);
        chk("hro_done_cyc", done_cyc, 54);
        // abort at round 9 of pass 2
        op(1'b1, -10, 0, 44, -1, -1, 50);
        chk("ab_rc44", snap_rc[44], 9); chk("ab_kc44", snap_kc[44], 2);
        chk("ab_busy45", snap_busy[45], 0); chk("ab_rc45", snap_rc[45], 0); chk("ab_kc45", snap_kc[45], 0);
        chk("ab_ke45", snap_ke[45], 0); chk("ab_rev45", snap_rev[45], 1);
        chk("ab_n_done", n_done, 0); chk("ab_n_kro", n_kro, 0);
        op(1'b0, -10, 0, -1, -1, -1, 54);
        chk("post_ab_done", done_cyc, 52); chk("post_ab_ke", n_ke, 51); chk("post_ab_kc1", snap_kc[1], 0);
        // asynchronous reset at round 3
        op(1'b1, -10, 0, -1, -1, -1, 4);
        chk("rm_rc4", snap_rc[4], 3);
        n_rst = 1'b0;
        #1;
        chk("rm_busy", busy, 0); chk("rm_ke", key_enable, 0); chk("rm_rc", round_count, 0);
        chk("rm_kc", key_count, 0); chk("rm_rev", reverse, 0); chk("rm_valid", subkey_valid, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        op(1'b0, -10, 0, -1, -1, -1, 54);
        chk("post_rst_done", done_cyc, 52); chk("post_rst_valid", n_valid, 48);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
